// File: rtl/alufun_pkg.sv
// ALUFun encodings, MIPS field constants and the decoded control struct
// shared by the ID-stage encoder and its combinational decoder.
package alufun_pkg;

    localparam logic [5:0] ALU_ADD    = 6'b000000;
    localparam logic [5:0] ALU_SUB    = 6'b000001;
    localparam logic [5:0] ALU_AND    = 6'b011000;
    localparam logic [5:0] ALU_OR     = 6'b011110;
    localparam logic [5:0] ALU_XOR    = 6'b010110;
    localparam logic [5:0] ALU_NOR    = 6'b010001;
    localparam logic [5:0] ALU_PASS_A = 6'b011010;
    localparam logic [5:0] ALU_SLL    = 6'b100000;
    localparam logic [5:0] ALU_SRL    = 6'b100001;
    localparam logic [5:0] ALU_SRA    = 6'b100011;
    localparam logic [5:0] ALU_EQ     = 6'b110011;
    localparam logic [5:0] ALU_NEQ    = 6'b110001;
    localparam logic [5:0] ALU_LT     = 6'b110101;
    localparam logic [5:0] ALU_LEZ    = 6'b111101;
    localparam logic [5:0] ALU_LTZ    = 6'b111011;
    localparam logic [5:0] ALU_GTZ    = 6'b111111;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef struct packed {
        logic [5:0] alufun;
        logic       sign;
        logic       is_branch;
        logic       br_invert;
        logic       illegal;
    } alu_ctrl_t;

    localparam alu_ctrl_t CTRL_BUBBLE  = '0;
    localparam alu_ctrl_t CTRL_ILLEGAL = '{alufun: ALU_ADD, sign: 1'b0, is_branch: 1'b0,
                                           br_invert: 1'b0, illegal: 1'b1};

    function automatic alu_ctrl_t mk_ctrl(input logic [5:0] alufun, input logic sign,
                                          input logic is_branch, input logic br_invert);
        mk_ctrl = '{alufun: alufun, sign: sign, is_branch: is_branch,
                    br_invert: br_invert, illegal: 1'b0};
    endfunction

endpackage

// File: rtl/alufun_encoder_if.sv
// ID-to-EX bundle of the ALUFun encoder: decode inputs, pipeline controls
// and the registered EX-stage control outputs.
interface alufun_encoder_if #(parameter int CNT_W = 8);

    logic             id_valid;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rt;
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [5:0]       ex_alufun;
    logic             ex_sign;
    logic             ex_is_branch;
    logic             ex_br_invert;
    logic             ex_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output id_valid, opcode, funct, rt, stall, flush,
        input  ex_valid, ex_alufun, ex_sign, ex_is_branch, ex_br_invert, ex_illegal, illegal_cnt
    );

    modport slave (
        input  id_valid, opcode, funct, rt, stall, flush,
        output ex_valid, ex_alufun, ex_sign, ex_is_branch, ex_br_invert, ex_illegal, illegal_cnt
    );

endinterface

// File: rtl/alufun_decode.sv
// Combinational opcode/funct/rt to ALU control decode.
// Define ALUFUN_SLTU_EN to accept sltu/sltiu as unsigned LT; otherwise they are illegal.
module alufun_decode
    import alufun_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    output alu_ctrl_t  o_ctrl
);

    always_comb begin
        // NOTE: default first so every path assigns o_ctrl and no latch is inferred.
        o_ctrl = CTRL_ILLEGAL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    F_ADD:  o_ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0);
                    F_ADDU: o_ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0);
                    F_SUB:  o_ctrl = mk_ctrl(ALU_SUB, 1'b1, 1'b0, 1'b0);
                    F_SUBU: o_ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0);
                    F_AND:  o_ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0);
                    F_OR:   o_ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0);
                    F_XOR:  o_ctrl = mk_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b0);
                    F_NOR:  o_ctrl = mk_ctrl(ALU_NOR, 1'b0, 1'b0, 1'b0);
                    F_SLL:  o_ctrl = mk_ctrl(ALU_SLL, 1'b0, 1'b0, 1'b0);
                    F_SRL:  o_ctrl = mk_ctrl(ALU_SRL, 1'b0, 1'b0, 1'b0);
                    F_SRA:  o_ctrl = mk_ctrl(ALU_SRA, 1'b0, 1'b0, 1'b0);
                    F_SLT:  o_ctrl = mk_ctrl(ALU_LT,  1'b1, 1'b0, 1'b0);
                    F_JR, F_JALR: o_ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0);
`ifdef ALUFUN_SLTU_EN
                    F_SLTU: o_ctrl = mk_ctrl(ALU_LT,  1'b0, 1'b0, 1'b0);
`else
                    F_SLTU: o_ctrl = CTRL_ILLEGAL;
`endif
                    default: o_ctrl = CTRL_ILLEGAL;
                endcase
            end
            OP_REGIMM: begin
                // bgez reuses the LTZ compare and takes the branch on a false result.
                if (i_rt == RT_BLTZ)      o_ctrl = mk_ctrl(ALU_LTZ, 1'b0, 1'b1, 1'b0);
                else if (i_rt == RT_BGEZ) o_ctrl = mk_ctrl(ALU_LTZ, 1'b0, 1'b1, 1'b1);
                else                      o_ctrl = CTRL_ILLEGAL;
            end
            OP_BEQ:  o_ctrl = mk_ctrl(ALU_EQ,  1'b0, 1'b1, 1'b0);
            OP_BNE:  o_ctrl = mk_ctrl(ALU_NEQ, 1'b0, 1'b1, 1'b0);
            OP_BLEZ: o_ctrl = mk_ctrl(ALU_LEZ, 1'b0, 1'b1, 1'b0);
            OP_BGTZ: o_ctrl = mk_ctrl(ALU_GTZ, 1'b0, 1'b1, 1'b0);
            OP_ADDI: o_ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0);
            OP_ADDIU, OP_LW, OP_SW, OP_LUI, OP_J, OP_JAL:
                     o_ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0);
            OP_ANDI: o_ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0);
            OP_ORI:  o_ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0);
            OP_XORI: o_ctrl = mk_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b0);
            OP_SLTI: o_ctrl = mk_ctrl(ALU_LT,  1'b1, 1'b0, 1'b0);
`ifdef ALUFUN_SLTU_EN
            OP_SLTIU: o_ctrl = mk_ctrl(ALU_LT, 1'b0, 1'b0, 1'b0);
`else
            OP_SLTIU: o_ctrl = CTRL_ILLEGAL;
`endif
            default: o_ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alufun_encoder.sv
// ID/EX register for the ALUFun control word plus a saturating illegal-instruction counter.
// sltu/sltiu acceptance follows ALUFUN_SLTU_EN inside alufun_decode.
module alufun_encoder
    import alufun_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    alufun_encoder_if.slave bus
);

    alu_ctrl_t        w_dec;
    alu_ctrl_t        w_next;
    logic             w_load;
    logic             w_count;
    alu_ctrl_t        r_ex;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    alufun_decode u_decode (
        .i_opcode (bus.opcode),
        .i_funct  (bus.funct),
        .i_rt     (bus.rt),
        .o_ctrl   (w_dec)
    );

    assign w_load  = !bus.flush && !bus.stall;
    assign w_next  = bus.id_valid ? w_dec : CTRL_BUBBLE;
    assign w_count = w_load && bus.id_valid && w_dec.illegal && (r_cnt != {CNT_W{1'b1}});

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ex    <= CTRL_BUBBLE;
            r_cnt   <= '0;
        end else begin
            if (bus.flush) begin
                r_valid <= 1'b0;
                r_ex    <= CTRL_BUBBLE;
            end else if (!bus.stall) begin
                r_valid <= bus.id_valid;
                r_ex    <= w_next;
            end
            if (w_count) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.ex_valid     = r_valid;
    assign bus.ex_alufun    = r_ex.alufun;
    assign bus.ex_sign      = r_ex.sign;
    assign bus.ex_is_branch = r_ex.is_branch;
    assign bus.ex_br_invert = r_ex.br_invert;
    assign bus.ex_illegal   = r_ex.illegal;
    assign bus.illegal_cnt  = r_cnt;

endmodule

// File: tb/tb_alufun_encoder.sv
// Directed bench for alufun_encoder; expectations adapt to ALUFUN_SLTU_EN.
`timescale 1ns/1ps
module tb_alufun_encoder;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [10:0] exp;
    } row_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alufun_encoder_if #(.CNT_W(8)) bus ();
    alufun_encoder_if #(.CNT_W(2)) bus2 ();

    alufun_encoder #(.CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    alufun_encoder #(.CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(bus2));

    // {valid, alufun[5:0], sign, is_branch, br_invert, illegal}
    logic [10:0] w_obs;
    assign w_obs = {bus.ex_valid, bus.ex_alufun, bus.ex_sign, bus.ex_is_branch,
                    bus.ex_br_invert, bus.ex_illegal};

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_cnt  = 8'd0;
    row_t       rows[$];

    function automatic logic [10:0] vec(input logic v, input logic [5:0] f, input logic s,
                                        input logic b, input logic i, input logic il);
        return {v, f, s, b, i, il};
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input logic st, input logic fl);
        bus.id_valid = v;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.rt       = rt;
        bus.stall    = st;
        bus.flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (w_obs !== 11'b0) begin
            n_errors++; $display("FAIL reset_fields: got %b expected %b", w_obs, 11'b0);
        end
        n_checks++;
        if (bus.illegal_cnt !== 8'd0) begin
            n_errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.illegal_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 5'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (w_obs !== vec(1, 6'b000000, 1, 0, 0, 0)) begin
            n_errors++; $display("FAIL reset_preload: got %b expected %b", w_obs, vec(1, 6'b000000, 1, 0, 0, 0));
        end
        drive(1'b1, 6'h00, 6'h26, 5'd0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (w_obs !== 11'b0) begin
            n_errors++; $display("FAIL reset_async_mid_stall: got %b expected %b", w_obs, 11'b0);
        end
        drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_checks++;
        if (w_obs !== 11'b0) begin
            n_errors++; $display("FAIL reset_release_idle: got %b expected %b", w_obs, 11'b0);
        end
        exp_cnt = 8'd0;
    endtask

    task automatic test_arith_seq();
        rows.delete();
        rows.push_back('{"add",  6'h00, 6'h20, 5'd0, vec(1, 6'b000000, 1, 0, 0, 0)});
        rows.push_back('{"addu", 6'h00, 6'h21, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"slti", 6'h0A, 6'h00, 5'd0, vec(1, 6'b110101, 1, 0, 0, 0)});
`ifdef ALUFUN_SLTU_EN
        rows.push_back('{"sltu", 6'h00, 6'h2B, 5'd0, vec(1, 6'b110101, 0, 0, 0, 0)});
`else
        rows.push_back('{"sltu", 6'h00, 6'h2B, 5'd0, vec(1, 6'b000000, 0, 0, 0, 1)});
`endif
        foreach (rows[i]) begin
            drive(1'b1, rows[i].op, rows[i].fn, rows[i].rt, 1'b0, 1'b0);
            tick();
            if (rows[i].exp[0]) exp_cnt++;
            n_checks++;
            if (w_obs !== rows[i].exp) begin
                n_errors++; $display("FAIL seq_%s: got %b expected %b", rows[i].name, w_obs, rows[i].exp);
            end
            n_checks++;
            if (bus.illegal_cnt !== exp_cnt) begin
                n_errors++; $display("FAIL seq_%s_cnt: got %0d expected %0d", rows[i].name, bus.illegal_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_alu_ops();
        rows.delete();
        rows.push_back('{"sub",   6'h00, 6'h22, 5'd0, vec(1, 6'b000001, 1, 0, 0, 0)});
        rows.push_back('{"subu",  6'h00, 6'h23, 5'd0, vec(1, 6'b000001, 0, 0, 0, 0)});
        rows.push_back('{"and",   6'h00, 6'h24, 5'd0, vec(1, 6'b011000, 0, 0, 0, 0)});
        rows.push_back('{"or",    6'h00, 6'h25, 5'd0, vec(1, 6'b011110, 0, 0, 0, 0)});
        rows.push_back('{"xor",   6'h00, 6'h26, 5'd0, vec(1, 6'b010110, 0, 0, 0, 0)});
        rows.push_back('{"nor",   6'h00, 6'h27, 5'd0, vec(1, 6'b010001, 0, 0, 0, 0)});
        rows.push_back('{"sll",   6'h00, 6'h00, 5'd0, vec(1, 6'b100000, 0, 0, 0, 0)});
        rows.push_back('{"srl",   6'h00, 6'h02, 5'd0, vec(1, 6'b100001, 0, 0, 0, 0)});
        rows.push_back('{"sra",   6'h00, 6'h03, 5'd0, vec(1, 6'b100011, 0, 0, 0, 0)});
        rows.push_back('{"slt",   6'h00, 6'h2A, 5'd0, vec(1, 6'b110101, 1, 0, 0, 0)});
        rows.push_back('{"jr",    6'h00, 6'h08, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"jalr",  6'h00, 6'h09, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"addi",  6'h08, 6'h00, 5'd0, vec(1, 6'b000000, 1, 0, 0, 0)});
        rows.push_back('{"addiu", 6'h09, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"andi",  6'h0C, 6'h00, 5'd0, vec(1, 6'b011000, 0, 0, 0, 0)});
        rows.push_back('{"ori",   6'h0D, 6'h00, 5'd0, vec(1, 6'b011110, 0, 0, 0, 0)});
        rows.push_back('{"xori",  6'h0E, 6'h00, 5'd0, vec(1, 6'b010110, 0, 0, 0, 0)});
        rows.push_back('{"lui",   6'h0F, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"lw",    6'h23, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"sw",    6'h2B, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"j",     6'h02, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
        rows.push_back('{"jal",   6'h03, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 0)});
`ifdef ALUFUN_SLTU_EN
        rows.push_back('{"sltiu", 6'h0B, 6'h00, 5'd0, vec(1, 6'b110101, 0, 0, 0, 0)});
`else
        rows.push_back('{"sltiu", 6'h0B, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 1)});
`endif
        rows.push_back('{"bad_funct", 6'h00, 6'h3F, 5'd0, vec(1, 6'b000000, 0, 0, 0, 1)});
        rows.push_back('{"bad_op",    6'h3F, 6'h00, 5'd0, vec(1, 6'b000000, 0, 0, 0, 1)});
        foreach (rows[i]) begin
            drive(1'b1, rows[i].op, rows[i].fn, rows[i].rt, 1'b0, 1'b0);
            tick();
            if (rows[i].exp[0]) exp_cnt++;
            n_checks++;
            if (w_obs !== rows[i].exp) begin
                n_errors++; $display("FAIL op_%s: got %b expected %b", rows[i].name, w_obs, rows[i].exp);
            end
            n_checks++;
            if (bus.illegal_cnt !== exp_cnt) begin
                n_errors++; $display("FAIL op_%s_cnt: got %0d expected %0d", rows[i].name, bus.illegal_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_branches();
        rows.delete();
        rows.push_back('{"beq",  6'h04, 6'h00, 5'd0, vec(1, 6'b110011, 0, 1, 0, 0)});
        rows.push_back('{"bne",  6'h05, 6'h00, 5'd0, vec(1, 6'b110001, 0, 1, 0, 0)});
        rows.push_back('{"blez", 6'h06, 6'h00, 5'd0, vec(1, 6'b111101, 0, 1, 0, 0)});
        rows.push_back('{"bgtz", 6'h07, 6'h00, 5'd0, vec(1, 6'b111111, 0, 1, 0, 0)});
        rows.push_back('{"bltz", 6'h01, 6'h00, 5'd0, vec(1, 6'b111011, 0, 1, 0, 0)});
        rows.push_back('{"bgez", 6'h01, 6'h00, 5'd1, vec(1, 6'b111011, 0, 1, 1, 0)});
        rows.push_back('{"regimm_rt2", 6'h01, 6'h00, 5'd2, vec(1, 6'b000000, 0, 0, 0, 1)});
        foreach (rows[i]) begin
            drive(1'b1, rows[i].op, rows[i].fn, rows[i].rt, 1'b0, 1'b0);
            tick();
            if (rows[i].exp[0]) exp_cnt++;
            n_checks++;
            if (w_obs !== rows[i].exp) begin
                n_errors++; $display("FAIL br_%s: got %b expected %b", rows[i].name, w_obs, rows[i].exp);
            end
            n_checks++;
            if (bus.illegal_cnt !== exp_cnt) begin
                n_errors++; $display("FAIL br_%s_cnt: got %0d expected %0d", rows[i].name, bus.illegal_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 6'h04, 6'h00, 5'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (w_obs !== vec(1, 6'b110011, 0, 1, 0, 0)) begin
            n_errors++; $display("FAIL stall_load_beq: got %b expected %b", w_obs, vec(1, 6'b110011, 0, 1, 0, 0));
        end
        drive(1'b1, 6'h00, 6'h26, 5'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (w_obs !== vec(1, 6'b110011, 0, 1, 0, 0)) begin
                n_errors++; $display("FAIL stall_hold_%0d: got %b expected %b", k, w_obs, vec(1, 6'b110011, 0, 1, 0, 0));
            end
        end
        drive(1'b1, 6'h00, 6'h26, 5'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (w_obs !== vec(1, 6'b010110, 0, 0, 0, 0)) begin
            n_errors++; $display("FAIL stall_release_xor: got %b expected %b", w_obs, vec(1, 6'b010110, 0, 0, 0, 0));
        end
        drive(1'b1, 6'h3F, 6'h00, 5'd0, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (w_obs !== vec(1, 6'b010110, 0, 0, 0, 0)) begin
            n_errors++; $display("FAIL stall_illegal_hold: got %b expected %b", w_obs, vec(1, 6'b010110, 0, 0, 0, 0));
        end
        n_checks++;
        if (bus.illegal_cnt !== exp_cnt) begin
            n_errors++; $display("FAIL stall_cnt_hold: got %0d expected %0d", bus.illegal_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 6'h3F, 6'h00, 5'd0, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (w_obs !== 11'b0) begin
            n_errors++; $display("FAIL flush_and_stall: got %b expected %b", w_obs, 11'b0);
        end
        n_checks++;
        if (bus.illegal_cnt !== exp_cnt) begin
            n_errors++; $display("FAIL flush_cnt: got %0d expected %0d", bus.illegal_cnt, exp_cnt);
        end
        drive(1'b1, 6'h00, 6'h20, 5'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (w_obs !== vec(1, 6'b000000, 1, 0, 0, 0)) begin
            n_errors++; $display("FAIL flush_preload: got %b expected %b", w_obs, vec(1, 6'b000000, 1, 0, 0, 0));
        end
        drive(1'b1, 6'h00, 6'h26, 5'd0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (w_obs !== 11'b0) begin
            n_errors++; $display("FAIL flush_only: got %b expected %b", w_obs, 11'b0);
        end
        drive(1'b0, 6'h3F, 6'h00, 5'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (w_obs !== 11'b0) begin
            n_errors++; $display("FAIL invalid_bubble: got %b expected %b", w_obs, 11'b0);
        end
        n_checks++;
        if (bus.illegal_cnt !== exp_cnt) begin
            n_errors++; $display("FAIL invalid_cnt: got %0d expected %0d", bus.illegal_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_sat;
        bus2.id_valid = 1'b1;
        bus2.opcode   = 6'h3F;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_sat = (k < 3) ? 2'(k + 1) : 2'd3;
            n_checks++;
            if (bus2.illegal_cnt !== exp_sat) begin
                n_errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, bus2.illegal_cnt, exp_sat);
            end
        end
        bus2.id_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 5'd0, 1'b0, 1'b0);
        bus2.id_valid = 1'b0;
        bus2.opcode   = 6'h00;
        bus2.funct    = 6'h00;
        bus2.rt       = 5'd0;
        bus2.stall    = 1'b0;
        bus2.flush    = 1'b0;
        test_reset();
        test_arith_seq();
        test_alu_ops();
        test_branches();
        test_stall();
        test_flush();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alufun_encoder.md
# alufun_encoder

- Decode-side encoder for the ALU function code consumed by the EX-stage ALU and its compare unit.
- Translates MIPS opcode/funct/rt fields into the 6-bit ALUFun code, the Sign flag and branch qualifiers.
- Registers the result into the ID/EX pipeline register with stall, flush and valid handling.
- Sits in the ID stage of the pipelined CPU; also usable unregistered-in-spirit by the single-cycle CPU via constant `id_valid=1`, `stall=0`, `flush=0`.

## Interface
Parameters:
- `CNT_W`, 8: width of the saturating illegal-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `opcode` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `rt` in 5: instr[20:16], for REGIMM decode.
- `stall` in 1: hold the ID/EX register.
- `flush` in 1: insert a bubble into ID/EX.
- `ex_valid` out 1: EX-stage instruction is valid.
- `ex_alufun` out 6: registered ALUFun.
- `ex_sign` out 1: signed compare/overflow select.
- `ex_is_branch` out 1: conditional branch; the ALU cmp bit decides it.
- `ex_br_invert` out 1: branch taken when cmp==0.
- `ex_illegal` out 1: EX instruction is undecodable.
- `illegal_cnt` out CNT_W: saturating count of illegal instructions accepted.

## Operation
ALUFun encodings:
- Arithmetic: ADD 000000, SUB 000001.
- Logic: AND 011000, OR 011110, XOR 010110, NOR 010001, PASS_A 011010.
- Shift: SLL 100000, SRL 100001, SRA 100011.
- Compare: EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.

Decode rules:
- R-type (opcode 0): add/addu→ADD; sub/subu→SUB; and/or/xor/nor; sll/srl/sra; slt→LT; jr/jalr→ADD.
  - sign=1 for add, sub and slt.
  - sign=0 for addu and subu.
- I-type:
  - addi, lw, sw, lui→ADD; addi has sign=1.
  - addiu→ADD, sign=0.
  - andi→AND; ori→OR; xori→XOR; slti→LT, sign=1.
- Branches set is_branch=1:
  - beq→EQ; bne→NEQ; blez→LEZ; bgtz→GTZ.
  - REGIMM (opcode 1): rt=0 bltz→LTZ; rt=1 bgez→LTZ with br_invert=1.
- j/jal→ADD, is_branch=0.
- Any other encoding (including REGIMM rt∉{0,1}):
  - illegal=1, alufun=ADD, is_branch=0.
  - Counted only when id_valid=1.

ID/EX register update, priority top-down at each rising edge:
1. `flush`: ex_valid=0, ex_alufun=000000, ex_sign=0, ex_is_branch=0, ex_br_invert=0, ex_illegal=0. Flush beats stall.
2. `stall`: all ex_* hold; counter holds.
3. Else: load the decoded fields. ex_valid=id_valid. When id_valid=0, the bubble values from rule 1 are loaded.

Counter:
- illegal_cnt increments on a load with id_valid=1 and illegal=1.
- Saturates at 2^CNT_W−1; no wrap-around.

## Timing
- Reset (async assert, any time, including mid-stall): every ex_* output = 0 and illegal_cnt=0, immediately.
- Reset release is synchronous to the next clk edge.
- Latency: one cycle. Fields presented in cycle N appear on ex_* after edge N+1.
- Stall holds indefinitely.
- Flush and stall in the same cycle: flush wins; the counter does not increment.
- The decode path is purely combinational and feeds only the register.

## Configuration
`ALUFUN_SLTU_EN`:
- Defined: sltu (R-type) and sltiu decode to LT with sign=0.
- Undefined: sltu and sltiu are illegal, flagged and counted.

## Structure
- Package `alufun_pkg` holds:
  - the ALUFun localparams above;
  - opcode, funct and REGIMM rt constants;
  - a packed struct `alu_ctrl_t` {alufun, sign, is_branch, br_invert, illegal}.
- Sub-module `alufun_decode`: purely combinational, opcode/funct/rt → alu_ctrl_t.
- Top level holds the ID/EX register and the counter.

## Test plan
- Reset low mid-stream with ex_valid=1 → all outputs 0 asynchronously; after release with id_valid=0 → outputs stay 0.
- Sequence: add, addu, slti, sltu (opcode0/funct 0x2B) → ex_alufun 000000/000000/110101/110101. Sign 1/0/1/0 with `ALUFUN_SLTU_EN` defined. Without the macro, the sltu slot gives illegal=1 and illegal_cnt=1.
- Branches: beq→110011; bne→110001; blez→111101; bgtz→111111; bltz (rt=0)→111011 invert=0; bgez (rt=1)→111011 invert=1. All with is_branch=1.
- Issue beq, then stall for 3 cycles while presenting xor → ex holds 110011 for 3 cycles. Next unstalled edge → 010110.
- Assert flush and stall together with an illegal opcode 0x3F → bubble (ex_valid=0, all fields 0); illegal_cnt unchanged.
- CNT_W=2: four valid illegal instructions → counter reads 1, 2, 3, 3 (saturated).
